// File: rtl/zap_decode_irq_inject_fsm.sv
// rtl/zap_decode_irq_inject_fsm.sv - FIQ/IRQ marker injection scheduler in front of the decoder
module zap_decode_irq_inject_fsm #(
  parameter logic [34:0] FIQ_INSTR      = 35'h0_EF00_0001,
  parameter logic [34:0] IRQ_INSTR      = 35'h0_EF00_0002,
  parameter int          HOLDOFF_CYCLES = 4,
  parameter int          FLUSH_TIMEOUT  = 64
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_cpsr_ff,
  input  logic        i_clear_from_writeback,
  input  logic        i_data_stall,
  input  logic        i_clear_from_alu,
  input  logic        i_stall_from_shifter,
  input  logic        i_stall_from_issue,
  input  logic        i_fiq,
  input  logic        i_irq,
  input  logic [34:0] i_instruction,
  input  logic        i_instruction_valid,
  output logic [34:0] o_instruction,
  output logic        o_instruction_valid,
  output logic        o_stall_from_decode,
  output logic        o_fiq_taken,
  output logic        o_irq_taken,
  output logic        o_flush_timeout
);

  localparam int TW = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;
  localparam int HW = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          fiq_taken_q, fiq_taken_d;
  logic          irq_taken_q, irq_taken_d;
  logic          flush_timeout_q, flush_timeout_d;

  logic fiq_req, irq_req, clr, stl;
  logic unused_cpsr;

  assign fiq_req     = i_fiq & ~i_cpsr_ff[6];
  assign irq_req     = i_irq & ~i_cpsr_ff[7];
  assign clr         = i_clear_from_writeback | i_clear_from_alu;
  assign stl         = i_data_stall | i_stall_from_shifter | i_stall_from_issue;
  assign unused_cpsr = ^{i_cpsr_ff[31:8], i_cpsr_ff[5:0]};

  always_comb begin
    state_d             = state_q;
    wait_cnt_d          = wait_cnt_q;
    hold_cnt_d          = hold_cnt_q;
    fiq_taken_d         = 1'b0;
    irq_taken_d         = 1'b0;
    flush_timeout_d     = 1'b0;
    o_instruction       = i_instruction;
    o_instruction_valid = i_instruction_valid;
    o_stall_from_decode = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_instruction_valid && (fiq_req || irq_req)) begin
          o_instruction       = fiq_req ? FIQ_INSTR : IRQ_INSTR;
          o_instruction_valid = 1'b1;
          o_stall_from_decode = 1'b1;
          // Commit only on a clean cycle; a stalled cycle re-evaluates next time.
          if (!clr && !stl) begin
            state_d     = ST_WAIT;
            wait_cnt_d  = '0;
            fiq_taken_d = fiq_req;
            irq_taken_d = ~fiq_req;
          end
        end
      end

      ST_WAIT: begin
        o_instruction_valid = 1'b0;
        o_stall_from_decode = 1'b1;
        if (clr) begin
          if (HOLDOFF_CYCLES > 0) begin
            state_d    = ST_HOLD;
            hold_cnt_d = HW'(HOLDOFF_CYCLES);
          end else begin
            state_d = ST_IDLE;
          end
        end else if (!stl) begin
          if (wait_cnt_q == TW'(FLUSH_TIMEOUT - 1)) begin
            state_d         = ST_IDLE;
            wait_cnt_d      = '0;
            flush_timeout_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end
      end

      ST_HOLD: begin
        // Holdoff runs on wall-clock cycles: neither stall nor flush pauses it.
        if (hold_cnt_q <= HW'(1)) begin
          state_d    = ST_IDLE;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q         <= ST_IDLE;
      wait_cnt_q      <= '0;
      hold_cnt_q      <= '0;
      fiq_taken_q     <= 1'b0;
      irq_taken_q     <= 1'b0;
      flush_timeout_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      wait_cnt_q      <= wait_cnt_d;
      hold_cnt_q      <= hold_cnt_d;
      fiq_taken_q     <= fiq_taken_d;
      irq_taken_q     <= irq_taken_d;
      flush_timeout_q <= flush_timeout_d;
    end
  end

  assign o_fiq_taken     = fiq_taken_q;
  assign o_irq_taken     = irq_taken_q;
  assign o_flush_timeout = flush_timeout_q;

endmodule

// File: tb/tb_zap_decode_irq_inject_fsm.sv
// tb/tb_zap_decode_irq_inject_fsm.sv - directed bench for the interrupt injection scheduler
module tb_zap_decode_irq_inject_fsm;

  localparam logic [34:0] FIQ_I = 35'h0_EF00_0001;
  localparam logic [34:0] IRQ_I = 35'h0_EF00_0002;
  localparam logic [34:0] NOP_I = 35'h0_E1A0_0000;
  localparam logic [34:0] MOV_I = 35'h0_E3A0_1005;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [31:0] i_cpsr_ff;
  logic        i_clear_from_writeback, i_data_stall, i_clear_from_alu;
  logic        i_stall_from_shifter, i_stall_from_issue;
  logic        i_fiq, i_irq;
  logic [34:0] i_instruction;
  logic        i_instruction_valid;
  logic [34:0] o_instruction;
  logic        o_instruction_valid, o_stall_from_decode;
  logic        o_fiq_taken, o_irq_taken, o_flush_timeout;

  int total = 0;
  int bad   = 0;

  zap_decode_irq_inject_fsm dut (
    .i_clk                  (i_clk),
    .i_reset                (i_reset),
    .i_cpsr_ff              (i_cpsr_ff),
    .i_clear_from_writeback (i_clear_from_writeback),
    .i_data_stall           (i_data_stall),
    .i_clear_from_alu       (i_clear_from_alu),
    .i_stall_from_shifter   (i_stall_from_shifter),
    .i_stall_from_issue     (i_stall_from_issue),
    .i_fiq                  (i_fiq),
    .i_irq                  (i_irq),
    .i_instruction          (i_instruction),
    .i_instruction_valid    (i_instruction_valid),
    .o_instruction          (o_instruction),
    .o_instruction_valid    (o_instruction_valid),
    .o_stall_from_decode    (o_stall_from_decode),
    .o_fiq_taken            (o_fiq_taken),
    .o_irq_taken            (o_irq_taken),
    .o_flush_timeout        (o_flush_timeout)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [34:0] got, input logic [34:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Flush from WAIT, then let the 4-cycle holdoff drain back to IDLE.
  task automatic flush_and_settle();
    i_clear_from_writeback = 1'b1;
    step();
    i_clear_from_writeback = 1'b0;
    i_fiq = 1'b0;
    i_irq = 1'b0;
    repeat (4) step();
  endtask

  initial begin
    i_reset = 1'b1;
    i_cpsr_ff = 32'h0;
    i_clear_from_writeback = 1'b0;
    i_data_stall = 1'b0;
    i_clear_from_alu = 1'b0;
    i_stall_from_shifter = 1'b0;
    i_stall_from_issue = 1'b0;
    i_fiq = 1'b0;
    i_irq = 1'b0;
    i_instruction = NOP_I;
    i_instruction_valid = 1'b1;
    #2;
    check("rst_instr", o_instruction, NOP_I);
    check("rst_valid", 35'(o_instruction_valid), 35'd1);
    check("rst_stall", 35'(o_stall_from_decode), 35'd0);
    check("rst_pulses", 35'({o_fiq_taken, o_irq_taken, o_flush_timeout}), 35'd0);
    step();
    i_reset = 1'b0;
    step();

    // IRQ injection, flush, holdoff of 4 cycles, re-injection on the 5th
    i_irq = 1'b1;
    #1;
    check("irq_instr", o_instruction, IRQ_I);
    check("irq_stall", 35'(o_stall_from_decode), 35'd1);
    check("irq_valid", 35'(o_instruction_valid), 35'd1);
    step();
    check("irq_taken", 35'({o_fiq_taken, o_irq_taken}), 35'b01);
    check("wait_valid", 35'(o_instruction_valid), 35'd0);
    check("wait_stall", 35'(o_stall_from_decode), 35'd1);
    step();
    check("irq_pulse_1cyc", 35'(o_irq_taken), 35'd0);
    i_clear_from_alu = 1'b1;
    step();
    i_clear_from_alu = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("hold_instr", o_instruction, NOP_I);
      check("hold_stall", 35'(o_stall_from_decode), 35'd0);
      step();
    end
    #1;
    check("reinject_instr", o_instruction, IRQ_I);
    step();
    check("reinject_taken", 35'(o_irq_taken), 35'd1);
    flush_and_settle();

    // FIQ wins a tie; with F masked the IRQ marker is used
    i_fiq = 1'b1;
    i_irq = 1'b1;
    #1;
    check("tie_instr", o_instruction, FIQ_I);
    step();
    check("tie_taken", 35'({o_fiq_taken, o_irq_taken}), 35'b10);
    flush_and_settle();
    i_cpsr_ff = 32'h0000_0040;
    i_fiq = 1'b1;
    i_irq = 1'b1;
    #1;
    check("fmask_instr", o_instruction, IRQ_I);
    step();
    check("fmask_taken", 35'({o_fiq_taken, o_irq_taken}), 35'b01);
    flush_and_settle();

    // IRQ masked: pure pass-through
    i_cpsr_ff = 32'h0000_0080;
    i_irq = 1'b1;
    #1;
    check("imask_instr", o_instruction, NOP_I);
    check("imask_stall", 35'(o_stall_from_decode), 35'd0);
    step();
    check("imask_taken", 35'({o_fiq_taken, o_irq_taken}), 35'd0);
    i_irq = 1'b0;
    i_cpsr_ff = 32'h0;

    // Flush timeout after 64 WAIT cycles; request dropped while waiting
    i_instruction = MOV_I;
    i_irq = 1'b1;
    step();
    i_irq = 1'b0;
    for (int k = 0; k < 63; k++) begin
      check("to_wait_stall", 35'({o_stall_from_decode, o_flush_timeout}), 35'b10);
      step();
    end
    check("to_not_yet", 35'(o_flush_timeout), 35'd0);
    step();
    check("to_pulse", 35'(o_flush_timeout), 35'd1);
    check("to_instr", o_instruction, MOV_I);
    check("to_valid", 35'(o_instruction_valid), 35'd1);
    check("to_stall", 35'(o_stall_from_decode), 35'd0);
    step();
    check("to_pulse_once", 35'(o_flush_timeout), 35'd0);

    // Clear exactly on the 64th WAIT cycle wins over the timeout
    i_irq = 1'b1;
    step();
    i_irq = 1'b0;
    repeat (63) step();
    i_clear_from_writeback = 1'b1;
    step();
    i_clear_from_writeback = 1'b0;
    check("clr64_no_to", 35'(o_flush_timeout), 35'd0);
    i_irq = 1'b1;
    #1;
    check("clr64_hold_instr", o_instruction, MOV_I);
    check("clr64_hold_stall", 35'(o_stall_from_decode), 35'd0);
    i_irq = 1'b0;
    repeat (4) step();

    // Stall during the injection cycle holds the marker and defers the commit
    i_instruction = NOP_I;
    i_stall_from_issue = 1'b1;
    i_irq = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stl_instr", o_instruction, IRQ_I);
      check("stl_stall", 35'(o_stall_from_decode), 35'd1);
      step();
      check("stl_no_pulse", 35'(o_irq_taken), 35'd0);
    end
    i_stall_from_issue = 1'b0;
    #1;
    check("stl_rel_instr", o_instruction, IRQ_I);
    step();
    check("stl_rel_taken", 35'(o_irq_taken), 35'd1);
    check("stl_rel_wait", 35'(o_instruction_valid), 35'd0);
    flush_and_settle();

    // Asynchronous reset in the middle of WAIT
    i_irq = 1'b1;
    step();
    i_irq = 1'b0;
    check("pre_rst_taken", 35'(o_irq_taken), 35'd1);
    i_reset = 1'b1;
    #1;
    check("arst_pulse", 35'({o_fiq_taken, o_irq_taken, o_flush_timeout}), 35'd0);
    check("arst_stall", 35'(o_stall_from_decode), 35'd0);
    check("arst_valid", 35'(o_instruction_valid), 35'd1);
    step();
    i_reset = 1'b0;
    step();
    check("post_rst_idle", 35'(o_stall_from_decode), 35'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
